// File: rtl/gigabit_ingress_fifo_reader_if.sv
// AXIStream: 32-bit AXI-Stream bundle whose tdest carries the frame VLAN.
interface AXIStream;
    typedef logic [11:0] vlan_t;

    logic        aclk;
    logic        areset_n;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    vlan_t       tdest;
    logic        tuser;

    modport transmitter (output aclk, areset_n, tvalid, tdata, tstrb, tlast, tdest, tuser,
                         input  tready);
    modport receiver    (input  aclk, areset_n, tvalid, tdata, tstrb, tlast, tdest, tuser,
                         output tready);
endinterface

// File: rtl/gigabit_ingress_fifo_reader.sv
// Read side of the per-port ingress buffer: header/data fetch from URAM, AXI-Stream replay.
// Optional counters frames_out/bytes_out are built when INGRESS_READER_STATS_EN is defined.
module gigabit_ingress_fifo_reader #(
    parameter int DEPTH          = 4096,
    parameter int ADDR_BITS      = $clog2(DEPTH),
    parameter int RD_LATENCY     = 3,
    parameter int PREFETCH_DEPTH = RD_LATENCY + 2
) (
    input  logic                 aclk,
    input  logic                 areset_n,
    output logic                 rd_en,
    output logic [ADDR_BITS-1:0] rd_addr,
    input  logic [71:0]          rd_data,
    input  logic [ADDR_BITS:0]   rd_size,
    input  logic [ADDR_BITS:0]   rd_ptr,
    output logic                 rd_ptr_inc,
`ifdef INGRESS_READER_STATS_EN
    output logic [31:0]          frames_out,
    output logic [31:0]          bytes_out,
`endif
    AXIStream.transmitter        axi_tx
);
    localparam int PW = (PREFETCH_DEPTH > 1) ? $clog2(PREFETCH_DEPTH) : 1;
    localparam int CW = $clog2(PREFETCH_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, HDR_WAIT, DATA} state_t;
    state_t state;

    logic [RD_LATENCY-1:0] vld_pipe;
    logic [ADDR_BITS:0]    fetch_ptr;
    logic [11:0]           vlan;
    logic [10:0]           len;
    logic [11:0]           fetched;
    logic [11:0]           beat_idx;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         occ;
    logic [PW-1:0]         wr_idx;
    logic [PW-1:0]         rd_idx;
    logic                  half;
    logic [63:0]           buf_mem [PREFETCH_DEPTH];

    logic [11:0] nwords;
    logic [11:0] nbeats;
    logic [10:0] hdr_len;
    logic        ret;
    logic        hdr_done;
    logic        push;
    logic        beat_valid;
    logic        hs;
    logic        last_beat;
    logic        pop;
    logic        issue;
    logic [3:0]  strb_last;
    logic        unused_bits;

    assign unused_bits = ^rd_data[71:64];

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (i == PW'(PREFETCH_DEPTH - 1)) ? '0 : i + PW'(1);
    endfunction

    always_comb begin
        nwords     = ({1'b0, len} + 12'd7) >> 3;
        nbeats     = ({1'b0, len} + 12'd3) >> 2;
        hdr_len    = rd_data[10:0];
        ret        = vld_pipe[RD_LATENCY-1];
        hdr_done   = (state == HDR_WAIT) && ret;
        push       = (state == DATA) && ret;
        beat_valid = (occ != '0);
        hs         = beat_valid && axi_tx.tready;
        last_beat  = (beat_idx == nbeats - 12'd1);
        // a word leaves the buffer after its high half, or its low half if it ends the frame
        pop        = hs && (half || last_beat);
        issue      = (state == DATA) && (fetched < nwords) &&
                     ((32'(inflight) + 32'(occ)) < PREFETCH_DEPTH);
        rd_ptr_inc = hdr_done || pop;
        case (len[1:0])
            2'd1:    strb_last = 4'b0001;
            2'd2:    strb_last = 4'b0011;
            2'd3:    strb_last = 4'b0111;
            default: strb_last = 4'b1111;
        endcase
    end

    assign axi_tx.aclk     = aclk;
    assign axi_tx.areset_n = areset_n;
    assign axi_tx.tvalid   = beat_valid;
    assign axi_tx.tdata    = !beat_valid ? 32'h0 :
                             (half ? buf_mem[rd_idx][63:32] : buf_mem[rd_idx][31:0]);
    assign axi_tx.tstrb    = !beat_valid ? 4'h0 : (last_beat ? strb_last : 4'hF);
    assign axi_tx.tlast    = beat_valid && last_beat;
    assign axi_tx.tdest    = beat_valid ? vlan : 12'h0;
    assign axi_tx.tuser    = 1'b0;

    always_ff @(posedge aclk) begin
        if (push) buf_mem[wr_idx] <= rd_data[63:0];
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state     <= IDLE;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            fetch_ptr <= '0;
            vlan      <= '0;
            len       <= '0;
            fetched   <= '0;
            beat_idx  <= '0;
            inflight  <= '0;
            occ       <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            half      <= 1'b0;
            vld_pipe  <= '0;
        end else begin
            rd_en       <= 1'b0;
            vld_pipe[0] <= rd_en;
            for (int i = 1; i < RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
            if (push) wr_idx <= next_idx(wr_idx);
            if (pop)  rd_idx <= next_idx(rd_idx);
            occ      <= occ + CW'(push) - CW'(pop);
            inflight <= inflight + CW'(issue) - CW'(push);
            if (hs) begin
                half     <= ~half;
                beat_idx <= beat_idx + 12'd1;
            end
            case (state)
                IDLE: begin
                    if (rd_size != '0 && occ == '0) begin
                        rd_en     <= 1'b1;
                        rd_addr   <= rd_ptr[ADDR_BITS-1:0];
                        fetch_ptr <= rd_ptr + 1'b1;
                        state     <= HDR_WAIT;
                    end
                end
                HDR_WAIT: begin
                    if (ret) begin
                        vlan     <= rd_data[27:16];
                        len      <= hdr_len;
                        beat_idx <= '0;
                        half     <= 1'b0;
                        if (hdr_len == '0) begin
                            state <= IDLE;
                        end else begin
                            // first data read goes out alongside the header latch to save a cycle
                            state     <= DATA;
                            rd_en     <= 1'b1;
                            rd_addr   <= fetch_ptr[ADDR_BITS-1:0];
                            fetch_ptr <= fetch_ptr + 1'b1;
                            fetched   <= 12'd1;
                            inflight  <= CW'(1);
                        end
                    end
                end
                DATA: begin
                    if (issue) begin
                        rd_en     <= 1'b1;
                        rd_addr   <= fetch_ptr[ADDR_BITS-1:0];
                        fetch_ptr <= fetch_ptr + 1'b1;
                        fetched   <= fetched + 12'd1;
                    end
                    if (hs && last_beat) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INGRESS_READER_STATS_EN
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            frames_out <= '0;
            bytes_out  <= '0;
        end else if (hs && last_beat) begin
            frames_out <= frames_out + 32'd1;
            bytes_out  <= bytes_out + 32'(len);
        end
    end
`endif
endmodule

// File: tb/tb_gigabit_ingress_fifo_reader.sv
// Self-checking bench for gigabit_ingress_fifo_reader: URAM/writer model plus per-frame beat reference.
module tb_gigabit_ingress_fifo_reader;
    localparam int DEPTH = 4096;
    localparam int AB    = 12;
    localparam int LAT   = 3;
    localparam int PD    = LAT + 2;

    logic          aclk = 1'b0;
    logic          areset_n = 1'b1;
    logic          rd_en;
    logic [AB-1:0] rd_addr;
    logic [71:0]   rd_data;
    logic [AB:0]   rd_size;
    logic [AB:0]   rd_ptr_m;
    logic [AB:0]   wr_comm = '0;
    logic [AB:0]   reset_ptr = '0;
    logic          rd_ptr_inc;
`ifdef INGRESS_READER_STATS_EN
    logic [31:0]   frames_out;
    logic [31:0]   bytes_out;
`endif
    logic          tready = 1'b0;
    logic          tvalid, tlast, tuser;
    logic [31:0]   tdata;
    logic [3:0]    tstrb;
    logic [11:0]   tdest;

    AXIStream axi_tx_if();
    assign axi_tx_if.tready = tready;
    assign tvalid = axi_tx_if.tvalid;
    assign tdata  = axi_tx_if.tdata;
    assign tstrb  = axi_tx_if.tstrb;
    assign tlast  = axi_tx_if.tlast;
    assign tdest  = axi_tx_if.tdest;
    assign tuser  = axi_tx_if.tuser;

    gigabit_ingress_fifo_reader #(.DEPTH(DEPTH), .RD_LATENCY(LAT)) dut (
        .aclk(aclk), .areset_n(areset_n), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_size(rd_size), .rd_ptr(rd_ptr_m), .rd_ptr_inc(rd_ptr_inc),
`ifdef INGRESS_READER_STATS_EN
        .frames_out(frames_out), .bytes_out(bytes_out),
`endif
        .axi_tx(axi_tx_if)
    );

    always #5 aclk = ~aclk;

    logic [71:0] mem [DEPTH];
    logic [71:0] pipe [LAT];
    always_ff @(posedge aclk) begin
        pipe[0] <= rd_en ? mem[rd_addr] : '0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rd_data = pipe[LAT-1];

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n)       rd_ptr_m <= reset_ptr;
        else if (rd_ptr_inc) rd_ptr_m <= rd_ptr_m + 1'b1;
    end
    assign rd_size = wr_comm - rd_ptr_m;

    int errors = 0, checks = 0;
    int rd_en_total = 0, inc_total = 0;
    int exp_frames = 0, exp_bytes = 0;
    logic [31:0]   exp_data [$];
    logic [3:0]    exp_strb [$];
    bit            exp_last [$];
    logic [11:0]   exp_dest [$];
    logic [AB-1:0] addr_log [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic [AB:0] start);
        reset_ptr = start;
        areset_n  = 1'b0;
        #1;
        check("reset_outputs", {rd_en, rd_addr, rd_ptr_inc, tvalid, tlast, tstrb, tdest, tuser}, 0);
`ifdef INGRESS_READER_STATS_EN
        check("reset_stats", {frames_out, bytes_out}, 0);
`endif
        wr_comm = start;
        exp_data.delete(); exp_strb.delete(); exp_last.delete(); exp_dest.delete();
        exp_frames = 0; exp_bytes = 0;
        repeat (2) @(posedge aclk);
        #1;
        areset_n = 1'b1;
        rd_en_total = 0; inc_total = 0;
    endtask

    task automatic load_frame(input logic [11:0] vlan, input logic [10:0] len);
        int nw, nb;
        logic [63:0] words [$];
        logic [63:0] w;
        logic [AB-1:0] a;
        nw = (int'(len) + 7) >> 3;
        nb = (int'(len) + 3) >> 2;
        a = wr_comm[AB-1:0];
        mem[a] = {8'($urandom), 36'h0, vlan, 5'h0, len};
        for (int k = 0; k < nw; k++) begin
            w = {$urandom, $urandom};
            a = a + 1'b1;
            mem[a] = {8'($urandom), w};
            words.push_back(w);
        end
        for (int i = 0; i < nb; i++) begin
            w = words[i/2] >> (32 * (i % 2));
            exp_data.push_back(w[31:0]);
            exp_last.push_back(i == nb - 1);
            exp_strb.push_back((i == nb - 1 && len[1:0] != 2'd0) ? 4'((1 << len[1:0]) - 1) : 4'hF);
            exp_dest.push_back(vlan);
        end
        wr_comm = wr_comm + 13'(1 + nw);
        exp_frames++;
        exp_bytes += int'(len);
    endtask

    task automatic run_stream(input int pct, input int stall_at,
                              output int first_valid, output int last_hs, output int n_last);
        int cyc = 0, beats = 0, stall = 0, extra = 0;
        bit stalled = 0, hold = 0, el;
        logic [49:0] prev = '0, cur;
        logic [31:0] ed;
        logic [3:0]  es;
        logic [11:0] edst;
        first_valid = -1; last_hs = -1; n_last = 0;
        while (exp_data.size() != 0 && cyc < 4000) begin
            @(posedge aclk); #1;
            cyc++;
            if (stall_at >= 0 && !stalled && beats >= stall_at) begin stall = 20; stalled = 1; end
            tready = (stall > 0) ? 1'b0 : ($urandom_range(99) < pct);
            if (stall > 0) stall--;
            #1;
            cur = {tvalid, tdata, tstrb, tlast, tdest};
            if (hold) check("axi_hold", cur, prev);
            hold = tvalid && !tready;
            prev = cur;
            if (rd_en) begin rd_en_total++; addr_log.push_back(rd_addr); end
            if (rd_ptr_inc) inc_total++;
            if (rd_en) check("prefetch_bound", 64'((rd_en_total - inc_total) <= PD), 1);
            if (first_valid < 0 && tvalid) first_valid = cyc;
            if (tvalid && tready) begin
                beats++;
                last_hs = cyc;
                if (tlast) n_last++;
                ed = exp_data.pop_front(); es = exp_strb.pop_front();
                el = exp_last.pop_front(); edst = exp_dest.pop_front();
                check("beat", {tdata, tstrb, tlast, el ? tdest : 12'h0},
                              {ed, es, el, el ? edst : 12'h0});
            end
        end
        check("stream_complete", exp_data.size(), 0);
        tready = 1'b1;
        repeat (4) begin
            @(posedge aclk); #2;
            if (tvalid) extra++;
            if (rd_en) rd_en_total++;
            if (rd_ptr_inc) inc_total++;
        end
        check("no_extra_beats", extra, 0);
    endtask

    task automatic run_and_check(input int nframes, input int exp_words, input int pct,
                                 input int stall_at, input bit tput, input int nb);
        logic [AB:0] p0;
        int i0, fv, lh, nl;
        p0 = rd_ptr_m;
        i0 = inc_total;
        run_stream(pct, stall_at, fv, lh, nl);
        check("tlast_count", nl, nframes);
        check("inc_pulses", inc_total - i0, exp_words);
        check("rd_ptr_advance", 13'(rd_ptr_m - p0), exp_words);
        check("rd_size_zero", rd_size, 0);
        if (tput) begin
            check("first_beat_latency", 64'(fv >= 1 && fv <= 2 * LAT + 3), 1);
            check("throughput", lh - fv, nb - 1);
        end
    endtask

    initial begin
        int seen, hs_seen;
        #1;
        do_reset(13'd0);
        seen = 0;
        repeat (5) begin @(posedge aclk); #2; if (rd_en || tvalid) seen++; end
        check("idle_no_size", seen, 0);

        load_frame(12'd5, 11'd60);
        run_and_check(1, 9, 100, -1, 1'b1, 15);

        load_frame(12'd6, 11'd61);
        run_and_check(1, 9, 100, -1, 1'b1, 16);

        load_frame(12'd3, 11'd1518);
        run_and_check(1, 191, 50, 100, 1'b0, 380);

        do_reset(13'd4093);
        addr_log.delete();
        load_frame(12'd9, 11'd64);
        run_and_check(1, 9, 100, -1, 1'b1, 16);
        check("wrap_addr_count", addr_log.size(), 9);
        for (int k = 0; k < 9 && k < addr_log.size(); k++)
            check("wrap_addr", addr_log[k], (4093 + k) % DEPTH);

        load_frame(12'd1, 11'd64);
        load_frame(12'd2, 11'd65);
        run_and_check(2, 19, 100, -1, 1'b0, 0);
`ifdef INGRESS_READER_STATS_EN
        check("frames_out", frames_out, exp_frames);
        check("bytes_out", bytes_out, exp_bytes);
`endif

        load_frame(12'd7, 11'd100);
        tready = 1'b1;
        hs_seen = 0;
        for (int c = 0; c < 200 && hs_seen < 5; c++) begin
            @(posedge aclk); #2;
            if (tvalid) hs_seen++;
        end
        check("reached_beat5", hs_seen, 5);
        do_reset(13'd0);
        seen = 0;
        repeat (10) begin @(posedge aclk); #2; if (rd_en || tvalid || rd_ptr_inc) seen++; end
        check("idle_after_reset", seen, 0);

        load_frame(12'd4, 11'd33);
        run_and_check(1, 6, 100, -1, 1'b1, 9);
`ifdef INGRESS_READER_STATS_EN
        check("frames_out_post_reset", frames_out, exp_frames);
        check("bytes_out_post_reset", bytes_out, exp_bytes);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end
endmodule
